// File: rtl/sort_8_batch_unloader_if.sv
// Batch-in / word-out handshake bundle for the 8-lane sort unloader.
// slave = the unloader itself, master = the side driving batches and consuming words.
interface sort_8_batch_unloader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data_0;
    logic [DATA_WIDTH-1:0] in_data_1;
    logic [DATA_WIDTH-1:0] in_data_2;
    logic [DATA_WIDTH-1:0] in_data_3;
    logic [DATA_WIDTH-1:0] in_data_4;
    logic [DATA_WIDTH-1:0] in_data_5;
    logic [DATA_WIDTH-1:0] in_data_6;
    logic [DATA_WIDTH-1:0] in_data_7;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [2:0]            out_index;
    logic                  out_last;
    logic                  order_err;
    logic                  err_clear;

    modport slave (
        input  in_valid, in_data_0, in_data_1, in_data_2, in_data_3,
               in_data_4, in_data_5, in_data_6, in_data_7,
               out_ready, err_clear,
        output in_ready, out_valid, out_data, out_index, out_last, order_err
    );

    modport master (
        output in_valid, in_data_0, in_data_1, in_data_2, in_data_3,
               in_data_4, in_data_5, in_data_6, in_data_7,
               out_ready, err_clear,
        input  in_ready, out_valid, out_data, out_index, out_last, order_err
    );
endinterface

// File: rtl/sort_8_batch_unloader.sv
// Captures sorted 8-word batches into a 2-slot ping-pong buffer and
// streams them out one word per cycle, flagging any non-ascending batch.
module sort_8_batch_unloader #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    sort_8_batch_unloader_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_e;

    cnt_e                  cnt_q, cnt_d;
    logic                  wr_slot_q, wr_slot_d;
    logic                  rd_slot_q, rd_slot_d;
    logic [2:0]            rd_idx_q, rd_idx_d;
    logic                  order_err_q, order_err_d;
    logic [DATA_WIDTH-1:0] slot_q [2][N];
    logic [DATA_WIDTH-1:0] lane [N];

    logic in_ready;
    logic out_valid;
    logic capture;
    logic pop;
    logic retire;
    logic batch_bad;

    assign lane[0] = bus.in_data_0;
    assign lane[1] = bus.in_data_1;
    assign lane[2] = bus.in_data_2;
    assign lane[3] = bus.in_data_3;
    assign lane[4] = bus.in_data_4;
    assign lane[5] = bus.in_data_5;
    assign lane[6] = bus.in_data_6;
    assign lane[7] = bus.in_data_7;

    // Handshake qualifiers; in_ready looks only at the pre-edge fill level.
    always_comb begin
        in_ready  = !rst && (cnt_q != FULL);
        out_valid = !rst && (cnt_q != EMPTY);
        capture   = bus.in_valid && in_ready;
        pop       = out_valid && bus.out_ready;
        retire    = pop && (rd_idx_q == 3'd7);
    end

    // Unsigned neighbour check across the incoming batch; equal is fine.
    always_comb begin
        batch_bad = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if (lane[i] > lane[i+1]) begin
                batch_bad = 1'b1;
            end
        end
    end

    // Next-state: pointers, fill level and sticky error.
    always_comb begin
        cnt_d       = cnt_q;
        wr_slot_d   = wr_slot_q;
        rd_slot_d   = rd_slot_q;
        rd_idx_d    = rd_idx_q;
        order_err_d = order_err_q;

        if (capture) begin
            wr_slot_d = ~wr_slot_q;
        end

        if (pop) begin
            rd_idx_d = rd_idx_q + 3'd1;
            if (retire) begin
                rd_slot_d = ~rd_slot_q;
            end
        end

        unique case ({capture, retire})
            2'b10:   cnt_d = (cnt_q == EMPTY) ? ONE : FULL;
            2'b01:   cnt_d = (cnt_q == FULL) ? ONE : EMPTY;
            default: cnt_d = cnt_q;
        endcase

        if (capture && batch_bad) begin
            order_err_d = 1'b1;
        end else if (bus.err_clear) begin
            order_err_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= EMPTY;
            wr_slot_q   <= 1'b0;
            rd_slot_q   <= 1'b0;
            rd_idx_q    <= 3'd0;
            order_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wr_slot_q   <= wr_slot_d;
            rd_slot_q   <= rd_slot_d;
            rd_idx_q    <= rd_idx_d;
            order_err_q <= order_err_d;
        end
    end

    // Slot storage; contents are don't-care until a batch lands.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N; i++) begin
                slot_q[wr_slot_q][i] <= lane[i];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? slot_q[rd_slot_q][rd_idx_q] : '0;
    assign bus.out_index = rd_idx_q;
    assign bus.out_last  = out_valid && (rd_idx_q == 3'd7);
    assign bus.order_err = order_err_q;
endmodule

// File: tb/tb_sort_8_batch_unloader.sv
// Bench for sort_8_batch_unloader: table vectors, corner sequences and random
// traffic checked every cycle against a word-queue reference model.
module tb_sort_8_batch_unloader;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sort_8_batch_unloader_if #(.DATA_WIDTH(DW)) bus ();

    sort_8_batch_unloader #(.DATA_WIDTH(DW), .N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [DW-1:0] lanes [8];
    assign bus.in_data_0 = lanes[0];
    assign bus.in_data_1 = lanes[1];
    assign bus.in_data_2 = lanes[2];
    assign bus.in_data_3 = lanes[3];
    assign bus.in_data_4 = lanes[4];
    assign bus.in_data_5 = lanes[5];
    assign bus.in_data_6 = lanes[6];
    assign bus.in_data_7 = lanes[7];

    int total = 0;
    int bad = 0;
    int ncap = 0;

    // Reference model: every word still owed to the consumer, in order.
    logic [DW-1:0] mq [$];
    bit            merr = 1'b0;

    typedef struct {
        logic [7:0][DW-1:0] d;
        bit                 exp_err;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired, %0d words left", name, mq.size());
    endtask

    // One clock: inputs already set after negedge; compare, then advance model.
    task automatic tick();
        int held;
        int idx;
        bit ein;
        bit eov;
        bit cap;
        bit pop;
        bit lbad;
        #1;
        held = (mq.size() + 7) / 8;
        ein  = !rst && (held < 2);
        eov  = !rst && (mq.size() > 0);
        idx  = (8 - (mq.size() % 8)) % 8;
        chk("in_ready", 64'(bus.in_ready), 64'(ein));
        chk("out_valid", 64'(bus.out_valid), 64'(eov));
        if (eov) begin
            chk("out_data", 64'(bus.out_data), 64'(mq[0]));
            chk("out_index", 64'(bus.out_index), 64'(idx));
            chk("out_last", 64'(bus.out_last), 64'(idx == 7));
        end else begin
            chk("out_data_idle", 64'(bus.out_data), 64'd0);
            chk("out_last_idle", 64'(bus.out_last), 64'd0);
        end
        chk("order_err", 64'(bus.order_err), 64'(merr));
        cap  = bus.in_valid && ein;
        pop  = eov && bus.out_ready;
        lbad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (lanes[i] > lanes[i+1]) lbad = 1'b1;
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            merr = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (cap) begin
                ncap++;
                for (int i = 0; i < 8; i++) mq.push_back(lanes[i]);
            end
            if (cap && lbad) merr = 1'b1;
            else if (bus.err_clear) merr = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && mq.size() > 0; c++) tick();
        if (mq.size() != 0) timeout(name);
    endtask

    task automatic rand_sorted();
        logic [DW-1:0] v;
        v = $urandom_range(0, 32'hFFFF_0000);
        for (int i = 0; i < 8; i++) begin
            lanes[i] = v;
            v = v + $urandom_range(0, 40);
        end
    endtask

    task automatic set_bad();
        lanes[0] = 5;  lanes[1] = 3;  lanes[2] = 7;  lanes[3] = 8;
        lanes[4] = 9;  lanes[5] = 10; lanes[6] = 11; lanes[7] = 12;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[0].d[i] = DW'(i + 1);
            tbl[2].d[i] = 32'hFFFF_FFFF;
            tbl[3].d[i] = 32'h0;
            tbl[4].d[i] = DW'(i / 2);
            tbl[5].d[i] = DW'(i + 2);
            tbl[6].d[i] = DW'(i + 1);
        end
        tbl[0].exp_err = 1'b0;
        tbl[1].d = {32'd12, 32'd11, 32'd10, 32'd9, 32'd8, 32'd7, 32'd3, 32'd5};
        tbl[1].exp_err = 1'b1;
        tbl[2].exp_err = 1'b0;
        tbl[3].exp_err = 1'b0;
        tbl[4].exp_err = 1'b0;
        tbl[5].d[0] = 32'h8000_0000;
        tbl[5].d[1] = 32'h1;
        tbl[5].exp_err = 1'b1;
        tbl[6].d[7] = 32'hFFFF_FFFF;
        tbl[6].exp_err = 1'b0;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.err_clear = 1'b0;
        for (int i = 0; i < 8; i++) lanes[i] = '0;
        @(posedge clk);
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Table: clear, capture, check the flag, drain in order.
        foreach (tbl[k]) begin
            bus.err_clear = 1'b1;
            tick();
            bus.err_clear = 1'b0;
            for (int i = 0; i < 8; i++) lanes[i] = tbl[k].d[i];
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b0;
            tick();
            chk($sformatf("vec%0d_err", k), 64'(bus.order_err),
                64'(tbl[k].exp_err));
            drain($sformatf("vec%0d_drain", k));
        end

        // Single batch captured with out_ready already high.
        for (int i = 0; i < 8; i++) lanes[i] = DW'(i + 1);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        drain("single");

        // Three back-to-back batches, no bubbles expected.
        ncap = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && ncap < 3; c++) begin
            rand_sorted();
            tick();
        end
        if (ncap < 3) timeout("b2b_capture");
        drain("b2b");

        // Error set, clear, and clear coincident with a bad capture.
        set_bad();
        bus.in_valid = 1'b1;
        tick();
        chk("bad_set", 64'(bus.order_err), 64'd1);
        drain("bad1");
        bus.err_clear = 1'b1;
        set_bad();
        bus.in_valid = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        chk("clear_vs_set", 64'(bus.order_err), 64'd1);
        drain("bad2");
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        chk("clear_alone", 64'(bus.order_err), 64'd0);

        // Reset in the middle of draining a full buffer.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rand_sorted();
        tick();
        rand_sorted();
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) lanes[i] = DW'(100 + i);
        bus.in_valid = 1'b1;
        tick();
        chk("post_rst_index", 64'(bus.out_index), 64'd0);
        chk("post_rst_data", 64'(bus.out_data), 64'd100);
        drain("post_rst");

        // Random traffic with 50% backpressure.
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.err_clear = ($urandom_range(0, 15) == 0);
            rand_sorted();
            if ($urandom_range(0, 7) == 0) begin
                lanes[2] = lanes[7] + 1;
            end
            tick();
        end
        bus.err_clear = 1'b0;
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
